// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline hazard bundle between the datapath (master) and hazard_ctrl_unit (slave)
//   pipeline in : L_EX, RF_LE_EX, RD_EX, RF_LE_MEM, RD_MEM, RF_LE_WB, RD_WB,
//                 RA_ID, RB_ID, USE_RA_ID, USE_RB_ID, BR_TAKEN_EX
//   control out : stall_F, stall_D, flush_D, flush_E, FWD_A, FWD_B, stall_cnt
interface hazard_ctrl_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 16
);
  logic          L_EX, RF_LE_EX, RF_LE_MEM, RF_LE_WB;
  logic          USE_RA_ID, USE_RB_ID, BR_TAKEN_EX;
  logic [AW-1:0] RD_EX, RD_MEM, RD_WB, RA_ID, RB_ID;
  logic          stall_F, stall_D, flush_D, flush_E;
  logic [1:0]    FWD_A, FWD_B;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output L_EX, RF_LE_EX, RF_LE_MEM, RF_LE_WB, USE_RA_ID, USE_RB_ID, BR_TAKEN_EX,
           RD_EX, RD_MEM, RD_WB, RA_ID, RB_ID,
    input  stall_F, stall_D, flush_D, flush_E, FWD_A, FWD_B, stall_cnt
  );
  modport slave (
    input  L_EX, RF_LE_EX, RF_LE_MEM, RF_LE_WB, USE_RA_ID, USE_RB_ID, BR_TAKEN_EX,
           RD_EX, RD_MEM, RD_WB, RA_ID, RB_ID,
    output stall_F, stall_D, flush_D, flush_E, FWD_A, FWD_B, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use stall FSM, branch flush and operand forwarding select
//   clk, rst_n (async, active-low); h: hazard_ctrl_if.slave carrying pipeline
//   register info in and stall/flush/forward controls out.
//   Optional macro HAZARD_PERF_CNT_EN adds a saturating stall-cycle counter on stall_cnt.
module hazard_ctrl_unit #(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave h
);
  typedef enum logic {IDLE, STALL} state_t;
  state_t     state, state_nx;
  logic [1:0] rem, rem_nx;
  logic       hz, stl, br, ex_w;
  assign br   = h.BR_TAKEN_EX;
  assign ex_w = h.RF_LE_EX & ~h.L_EX;
  assign hz = h.L_EX & h.RF_LE_EX & (h.RD_EX != '0) &
              ((h.USE_RA_ID & (h.RD_EX == h.RA_ID)) | (h.USE_RB_ID & (h.RD_EX == h.RB_ID)));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
    end
  // A taken branch wins over everything: it squashes the dependent instruction anyway.
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    stl      = 1'b0;
    if (br) begin
      state_nx = IDLE;
      rem_nx   = '0;
    end else if (state == STALL) begin
      stl      = 1'b1;
      state_nx = rem == '0 ? IDLE : STALL;
      rem_nx   = rem == '0 ? rem : rem - 2'd1;
    end else if (hz) begin
      stl      = 1'b1;
      state_nx = LOAD_LAT > 1 ? STALL : IDLE;
      rem_nx   = LOAD_LAT > 1 ? 2'(LOAD_LAT - 2) : 2'd0;
    end
  end
  assign h.stall_F = rst_n & stl;
  assign h.stall_D = rst_n & stl;
  assign h.flush_D = rst_n & br;
  assign h.flush_E = rst_n & (stl | br);
  // A load result is not ready in EX, so EX forwarding excludes loads.
  assign h.FWD_A = (!rst_n || !h.USE_RA_ID || h.RA_ID == '0) ? 2'b00 :
                   (ex_w && h.RD_EX == h.RA_ID)         ? 2'b01 :
                   (h.RF_LE_MEM && h.RD_MEM == h.RA_ID) ? 2'b10 :
                   (h.RF_LE_WB && h.RD_WB == h.RA_ID)   ? 2'b11 : 2'b00;
  assign h.FWD_B = (!rst_n || !h.USE_RB_ID || h.RB_ID == '0) ? 2'b00 :
                   (ex_w && h.RD_EX == h.RB_ID)         ? 2'b01 :
                   (h.RF_LE_MEM && h.RD_MEM == h.RB_ID) ? 2'b10 :
                   (h.RF_LE_WB && h.RD_WB == h.RB_ID)   ? 2'b11 : 2'b00;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (h.stall_F && !(&cnt)) cnt <= cnt + 1'b1;
  assign h.stall_cnt = cnt;
`else
  assign h.stall_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: scoreboard bench driving LOAD_LAT=1 and LOAD_LAT=3 instances in parallel
module tb_hazard_ctrl_unit;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif
  localparam logic [7:0] Z = 8'h00, STL = 8'b1101_0000, BRK = 8'b0011_0000;
  typedef struct {
    string       nm;
    bit          sel;
    logic [7:0]  o;
    bit          chk;
    logic [15:0] cnt;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic l_ex, le_ex, le_mem, le_wb, ua, ub, br;
  logic [4:0] rd_ex, rd_mem, rd_wb, ra, rb;
  int n_cmp = 0, n_bad = 0;
  exp_t q[$];
  hazard_ctrl_if #(.AW(5), .CNT_W(16)) i1 ();
  hazard_ctrl_if #(.AW(5), .CNT_W(16)) i3 ();
  assign {i1.L_EX, i3.L_EX} = {2{l_ex}};
  assign {i1.RF_LE_EX, i3.RF_LE_EX} = {2{le_ex}};
  assign {i1.RF_LE_MEM, i3.RF_LE_MEM} = {2{le_mem}};
  assign {i1.RF_LE_WB, i3.RF_LE_WB} = {2{le_wb}};
  assign {i1.USE_RA_ID, i3.USE_RA_ID} = {2{ua}};
  assign {i1.USE_RB_ID, i3.USE_RB_ID} = {2{ub}};
  assign {i1.BR_TAKEN_EX, i3.BR_TAKEN_EX} = {2{br}};
  assign {i1.RD_EX, i3.RD_EX} = {2{rd_ex}};
  assign {i1.RD_MEM, i3.RD_MEM} = {2{rd_mem}};
  assign {i1.RD_WB, i3.RD_WB} = {2{rd_wb}};
  assign {i1.RA_ID, i3.RA_ID} = {2{ra}};
  assign {i1.RB_ID, i3.RB_ID} = {2{rb}};
  hazard_ctrl_unit #(.AW(5), .LOAD_LAT(1), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .h(i1.slave));
  hazard_ctrl_unit #(.AW(5), .LOAD_LAT(3), .CNT_W(16)) u3 (.clk(clk), .rst_n(rst_n), .h(i3.slave));
  always #5 clk = ~clk;
  task automatic drv(input logic l, input logic lee, input logic [4:0] rde, input logic lem,
                     input logic [4:0] rdm, input logic lew, input logic [4:0] rdw,
                     input logic [4:0] a, input logic uaa, input logic [4:0] b, input logic ubb,
                     input logic brr);
    l_ex = l; le_ex = lee; rd_ex = rde; le_mem = lem; rd_mem = rdm; le_wb = lew; rd_wb = rdw;
    ra = a; ua = uaa; rb = b; ub = ubb; br = brr;
  endtask
  task automatic drv0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic hzd(input logic brr);
    drv(1, 1, 5, 0, 0, 0, 0, 5, 1, 0, 0, brr);
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input string nm, input bit sel, input logic [7:0] o,
                    input bit chk = 1'b0, input int cnt = 0);
    exp_t e;
    e.nm = nm; e.sel = sel; e.o = o; e.chk = chk; e.cnt = 16'(cnt);
    q.push_back(e);
  endtask
  // monitor: outputs are combinational, so each queued expectation is checked mid-cycle
  initial forever begin
    exp_t e;
    logic [7:0] a;
    logic [15:0] c;
    @(negedge clk);
    while (q.size() != 0) begin
      e = q.pop_front();
      a = e.sel ? {i3.stall_F, i3.stall_D, i3.flush_D, i3.flush_E, i3.FWD_A, i3.FWD_B}
                : {i1.stall_F, i1.stall_D, i1.flush_D, i1.flush_E, i1.FWD_A, i1.FWD_B};
      c = e.sel ? i3.stall_cnt : i1.stall_cnt;
      n_cmp++;
      if (a !== e.o || (e.chk && c !== e.cnt)) begin
        n_bad++;
        $display("FAIL %s: got {sF,sD,fD,fE,A,B}=%b cnt=%0d, want %b cnt=%0d%s",
                 e.nm, a, c, e.o, e.cnt, e.chk ? "" : " (cnt not checked)");
      end
    end
  end
  initial begin
    drv(1, 1, 5, 1, 5, 0, 0, 5, 1, 5, 1, 1);
    nxt; ex("rst_out1", 0, Z, 1, 0); ex("rst_out3", 1, Z, 1, 0);
    nxt; rst_n = 1'b1; drv0;
    nxt; hzd(0); ex("hz1", 0, STL); ex("hz3", 1, STL);
    nxt; drv0; ex("post1", 0, Z); ex("stall2_3", 1, STL);
    nxt; ex("post1b", 0, Z); ex("stall3_3", 1, STL);
    nxt; ex("idle3", 1, Z, 1, PC ? 3 : 0); ex("cnt1", 0, Z, 1, PC ? 1 : 0);
    nxt; hzd(0); ex("hzA1", 0, STL); ex("hzA3", 1, STL);
    nxt; drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); ex("brk1", 0, BRK); ex("brk3", 1, BRK);
    nxt; drv0; ex("abort3", 1, Z, 1, PC ? 4 : 0); ex("abort1", 0, Z, 1, PC ? 2 : 0);
    nxt; hzd(1); ex("hzbr1", 0, BRK); ex("hzbr3", 1, BRK);
    nxt; drv0; ex("nostall3", 1, Z, 1, PC ? 4 : 0);
    nxt; drv(0, 1, 7, 1, 7, 1, 7, 7, 1, 7, 0, 0); ex("fwd_ex1", 0, 8'b0000_01_00); ex("fwd_ex3", 1, 8'b0000_01_00);
    nxt; drv(0, 0, 7, 1, 7, 1, 7, 7, 1, 7, 0, 0); ex("fwd_mem", 0, 8'b0000_10_00);
    nxt; drv(0, 0, 7, 0, 7, 1, 7, 7, 1, 7, 0, 0); ex("fwd_wb", 0, 8'b0000_11_00);
    nxt; drv(0, 0, 7, 0, 7, 0, 7, 7, 1, 7, 0, 0); ex("fwd_rf", 0, Z);
    nxt; drv(1, 1, 7, 1, 7, 0, 0, 2, 1, 7, 1, 0); ex("hzB1", 0, 8'b1101_0010); ex("hzB3", 1, 8'b1101_0010);
    nxt; rst_n = 1'b0; ex("rst_mid3", 1, Z, 1, 0); ex("rst_mid1", 0, Z, 1, 0);
    nxt; rst_n = 1'b1; drv0; ex("rel3", 1, Z, 1, 0);
    nxt; ex("rel3b", 1, Z, 1, 0);
    nxt; drv(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0); ex("r0_1", 0, Z); ex("r0_3", 1, Z);
    nxt; drv(1, 1, 3, 0, 0, 1, 4, 3, 0, 4, 1, 0); ex("use_gate1", 0, 8'b0000_0011); ex("use_gate3", 1, 8'b0000_0011);
    nxt; drv0;
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
